// File: rtl/sync_fifo_ctrl_pkg.sv
// sync_fifo_ctrl_pkg: shared constants and handshake helpers for the FIFO controller
package sync_fifo_ctrl_pkg;
  localparam int CNT_EXTRA = 2;
  function automatic int depth(input int aw);
    return 1 << aw;
  endfunction
  function automatic logic fire(input logic valid, input logic ready);
    return valid & ready;
  endfunction
endpackage

// File: rtl/fifo_out_buf.sv
// fifo_out_buf: 2-entry output buffer with bypass of the arriving RAM word into an empty head
module fifo_out_buf #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  pop,
  output logic                  head_valid,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [1:0]            occ
);
  logic                  v0, v1, p0v, p1v, ld;
  logic [DATA_WIDTH-1:0] d0, d1, p0d;
  assign head_valid = v0 | load;
  assign head_data  = (~v0 & load) ? load_data : d0;
  assign occ        = {v0 & v1, v0 ^ v1};
  // ld is the returning word still present after this cycle's pop (a bypassed word popped at once is gone)
  always_comb begin
    p0v = pop ? v1 : v0;
    p0d = pop ? d1 : d0;
    p1v = pop ? 1'b0 : v1;
    ld  = load & ~(pop & ~v0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
      d0 <= '0;
      d1 <= '0;
    end else if (flush) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
      d0 <= '0;
      d1 <= '0;
    end else begin
      v0 <= p0v | ld;
      d0 <= p0v ? p0d : ld ? load_data : d0;
      v1 <= p1v | (ld & p0v);
      d1 <= (ld & p0v & ~p1v) ? load_data : d1;
    end
  end
endmodule

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: FWFT FIFO controller over an external 1-cycle-read simple dual-port RAM
module sync_fifo_ctrl
  import sync_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_WIDTH-1:0]   s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATA_WIDTH-1:0]   m_data,
  output logic [ADDR_WIDTH+1:0]   count,
  output logic                    ram_w_ena,
  output logic [ADDR_WIDTH-1:0]   ram_w_addr,
  output logic [DATA_WIDTH-1:0]   ram_w_data,
  output logic                    ram_r_ena,
  output logic [ADDR_WIDTH-1:0]   ram_r_addr,
  input  logic [DATA_WIDTH-1:0]   ram_r_data
);
  localparam int CW = ADDR_WIDTH + CNT_EXTRA;
  localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH+1)'(depth(ADDR_WIDTH));
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   ram_cnt;
  logic                  rd_pending, push, pop, issue, head_valid;
  logic [1:0]            occ;
  assign s_ready    = rst_n & ~flush & (ram_cnt != FULL);
  assign m_valid    = head_valid & ~flush;
  assign push       = fire(s_valid, s_ready);
  assign pop        = fire(m_valid, m_ready);
  // a pending return already owns a buffer slot, so only issue when one stays free after this pop
  assign issue      = rst_n & ~flush & (ram_cnt != '0) &
                      (({1'b0, occ} + {2'b0, rd_pending}) < (3'd2 + {2'b0, pop}));
  assign ram_w_ena  = push;
  assign ram_w_addr = wr_ptr;
  assign ram_w_data = s_data;
  assign ram_r_ena  = issue;
  assign ram_r_addr = rd_ptr;
  fifo_out_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .load      (rd_pending),
    .load_data (ram_r_data),
    .pop       (pop),
    .head_valid(head_valid),
    .head_data (m_data),
    .occ       (occ)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ram_cnt    <= '0;
      rd_pending <= 1'b0;
      count      <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ram_cnt    <= '0;
      rd_pending <= 1'b0;
      count      <= '0;
    end else begin
      wr_ptr     <= wr_ptr + ADDR_WIDTH'(push);
      rd_ptr     <= rd_ptr + ADDR_WIDTH'(issue);
      ram_cnt    <= ram_cnt + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(issue);
      rd_pending <= issue;
      count      <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl: randomized scoreboard bench for sync_fifo_ctrl with an 8-deep RAM model
module tb_sync_fifo_ctrl;
  localparam int DW = 32;
  localparam int AW = 3;
  localparam int CAP = (1 << AW) + 2;
  logic          clk = 1'b0, rst_n = 1'b0, flush = 1'b0, s_valid = 1'b0, m_ready = 1'b0;
  logic [DW-1:0] s_data = '0, m_data, ram_w_data, ram_r_data;
  logic          s_ready, m_valid, ram_w_ena, ram_r_ena;
  logic [AW+1:0] count;
  logic [AW-1:0] ram_w_addr, ram_r_addr;
  logic [DW-1:0] mem [1 << AW];
  logic [DW-1:0] q [$];
  int            wa, ra, n_chk, n_pass;
  always #5 clk = ~clk;
  sync_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .count(count),
    .ram_w_ena(ram_w_ena), .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data),
    .ram_r_ena(ram_r_ena), .ram_r_addr(ram_r_addr), .ram_r_data(ram_r_data)
  );
  always @(posedge clk) begin
    if (ram_w_ena) mem[ram_w_addr] <= ram_w_data;
    if (ram_r_ena) ram_r_data <= mem[ram_r_addr];
  end
  task automatic do_flush;
    flush = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    q.delete(); wa = 0; ra = 0;
  endtask
  task automatic run_traffic(input int n, input int pv, input int pr, output int cyc);
    int sent = 0;
    logic prev_hold = 1'b0;
    logic [DW-1:0] prev_data = '0;
    cyc = 0;
    while ((sent < n || q.size() != 0) && cyc < 20000) begin
      s_valid = (sent < n) && ($urandom_range(99) < pv);
      s_data  = $urandom;
      m_ready = $urandom_range(99) < pr;
      @(negedge clk);
      n_chk++; if (count !== (AW+2)'(q.size())) $display("FAIL count got %0d want %0d", count, q.size()); else n_pass++;
      n_chk++; if (q.size() > CAP) $display("FAIL capacity got %0d want <=%0d", q.size(), CAP); else n_pass++;
      n_chk++; if (m_valid && q.size() == 0) $display("FAIL m_valid_empty got 1 want 0"); else n_pass++;
      if (m_valid && q.size() != 0) begin
        n_chk++; if (m_data !== q[0]) $display("FAIL order got %h want %h", m_data, q[0]); else n_pass++;
      end
      if (prev_hold) begin
        n_chk++; if (!m_valid || m_data !== prev_data) $display("FAIL hold got %b/%h want 1/%h", m_valid, m_data, prev_data); else n_pass++;
      end
      n_chk++; if (ram_w_ena !== (s_valid && s_ready)) $display("FAIL w_ena got %b want %b", ram_w_ena, s_valid && s_ready); else n_pass++;
      if (ram_w_ena) begin
        n_chk++; if (ram_w_addr !== AW'(wa) || ram_w_data !== s_data) $display("FAIL w_addr got %0d want %0d", ram_w_addr, AW'(wa)); else n_pass++;
      end
      if (ram_r_ena) begin
        n_chk++; if (ram_r_addr !== AW'(ra)) $display("FAIL r_addr got %0d want %0d", ram_r_addr, AW'(ra)); else n_pass++;
      end
      if (s_valid && s_ready) begin q.push_back(s_data); sent++; wa++; end
      if (m_valid && m_ready && q.size() != 0) void'(q.pop_front());
      if (ram_r_ena) ra++;
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
      @(posedge clk); #1;
      cyc++;
    end
    s_valid = 1'b0; m_ready = 1'b0;
    n_chk++; if (sent < n || q.size() != 0) $display("FAIL traffic_timeout sent %0d of %0d left %0d", sent, n, q.size()); else n_pass++;
  endtask
  task automatic test_reset;
    rst_n = 1'b0; s_valid = 1'b1; s_data = '1; m_ready = 1'b1;
    @(negedge clk);
    n_chk++; if (s_ready !== 1'b0) $display("FAIL rst_s_ready got %b want 0", s_ready); else n_pass++;
    n_chk++; if (m_valid !== 1'b0) $display("FAIL rst_m_valid got %b want 0", m_valid); else n_pass++;
    n_chk++; if (m_data !== '0) $display("FAIL rst_m_data got %h want 0", m_data); else n_pass++;
    n_chk++; if (count !== '0) $display("FAIL rst_count got %0d want 0", count); else n_pass++;
    n_chk++; if ({ram_w_ena, ram_r_ena} !== 2'b00) $display("FAIL rst_ena got %b want 00", {ram_w_ena, ram_r_ena}); else n_pass++;
    n_chk++; if ({ram_w_addr, ram_r_addr} !== '0) $display("FAIL rst_addr got %h want 0", {ram_w_addr, ram_r_addr}); else n_pass++;
    s_valid = 1'b0; m_ready = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if (s_ready !== 1'b1) $display("FAIL post_rst_s_ready got %b want 1", s_ready); else n_pass++;
  endtask
  task automatic test_first_word;
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = 32'h11; m_ready = 1'b0;
    @(negedge clk);
    n_chk++; if ({ram_w_ena, ram_w_addr} !== {1'b1, 3'd0} || ram_w_data !== 32'h11) $display("FAIL first_write got %b/%0d/%h want 1/0/11", ram_w_ena, ram_w_addr, ram_w_data); else n_pass++;
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(negedge clk);
    n_chk++; if ({ram_r_ena, ram_r_addr} !== {1'b1, 3'd0}) $display("FAIL first_read got %b/%0d want 1/0", ram_r_ena, ram_r_addr); else n_pass++;
    n_chk++; if (m_valid !== 1'b0) $display("FAIL first_early got %b want 0", m_valid); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++; if (m_valid !== 1'b1 || m_data !== 32'h11) $display("FAIL first_out got %b/%h want 1/11", m_valid, m_data); else n_pass++;
    n_chk++; if (count !== 5'd1) $display("FAIL first_count got %0d want 1", count); else n_pass++;
    @(posedge clk); #1;
    do_flush;
  endtask
  task automatic test_fill_drain;
    int acc = 0;
    m_ready = 1'b0;
    for (int v = 0; v < 12; v++) begin
      s_valid = 1'b1; s_data = 32'(v);
      @(negedge clk);
      if (s_ready) acc++;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    n_chk++; if (acc != CAP) $display("FAIL fill_accepted got %0d want %0d", acc, CAP); else n_pass++;
    @(negedge clk);
    n_chk++; if (s_ready !== 1'b0) $display("FAIL full_s_ready got %b want 0", s_ready); else n_pass++;
    n_chk++; if (count !== 5'(CAP)) $display("FAIL full_count got %0d want %0d", count, CAP); else n_pass++;
    @(posedge clk); #1;
    m_ready = 1'b1;
    for (int i = 0; i < CAP; i++) begin
      @(negedge clk);
      n_chk++; if (m_valid !== 1'b1 || m_data !== 32'(i)) $display("FAIL drain got %b/%0d want 1/%0d", m_valid, m_data, i); else n_pass++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_chk++; if (m_valid !== 1'b0 || count !== '0) $display("FAIL drained got %b/%0d want 0/0", m_valid, count); else n_pass++;
    @(posedge clk); #1;
    do_flush;
  endtask
  task automatic test_stream;
    int cyc;
    run_traffic(40, 100, 100, cyc);
    n_chk++; if (cyc > 43) $display("FAIL stream_cycles got %0d want <=43", cyc); else n_pass++;
    n_chk++; if (wa != 40 || ra != 40) $display("FAIL stream_ptrs got %0d/%0d want 40/40", wa, ra); else n_pass++;
    do_flush;
  endtask
  task automatic test_random;
    int cyc;
    run_traffic(1000, 50, 50, cyc);
    do_flush;
  endtask
  task automatic test_flush;
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s_valid = 1'b1; s_data = 32'h100 + 32'(i);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0; flush = 1'b1; s_valid = 1'b1; s_data = 32'hDEAD;
    @(negedge clk);
    n_chk++; if ({ram_w_ena, ram_r_ena} !== 2'b00) $display("FAIL flush_ena got %b want 00", {ram_w_ena, ram_r_ena}); else n_pass++;
    @(posedge clk); #1;
    flush = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    n_chk++; if (count !== '0 || m_valid !== 1'b0) $display("FAIL flush_state got %0d/%b want 0/0", count, m_valid); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++; if (m_valid !== 1'b0) $display("FAIL flush_ghost got %b want 0", m_valid); else n_pass++;
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = 32'hAB;
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++; if (m_valid !== 1'b1 || m_data !== 32'hAB) $display("FAIL flush_next got %b/%h want 1/ab", m_valid, m_data); else n_pass++;
    @(posedge clk); #1;
    do_flush;
  endtask
  task automatic test_async_reset;
    int waited = 0;
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_valid = 1'b1; s_data = 32'h200 + 32'(i);
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if ({m_valid, s_ready, ram_w_ena, ram_r_ena} !== 4'b0000) $display("FAIL async_rst got %b want 0000", {m_valid, s_ready, ram_w_ena, ram_r_ena}); else n_pass++;
    n_chk++; if (count !== '0 || m_data !== '0) $display("FAIL async_rst_state got %0d/%h want 0/0", count, m_data); else n_pass++;
    @(negedge clk);
    s_data = 32'h55; m_ready = 1'b0;
    #2 rst_n = 1'b1;
    q.delete(); wa = 0; ra = 0;
    @(posedge clk); #1;
    s_valid = 1'b0;
    while (!m_valid && waited < 8) begin
      @(posedge clk); #1;
      waited++;
    end
    @(negedge clk);
    n_chk++; if (m_valid !== 1'b1 || m_data !== 32'h55) $display("FAIL post_rst_first got %b/%h want 1/55", m_valid, m_data); else n_pass++;
    n_chk++; if (count !== 5'd1) $display("FAIL post_rst_count got %0d want 1", count); else n_pass++;
    @(posedge clk); #1;
    do_flush;
  endtask
  initial begin
    n_chk = 0; n_pass = 0; wa = 0; ra = 0;
    test_reset;
    test_first_word;
    test_fill_drain;
    test_stream;
    test_random;
    test_flush;
    test_async_reset;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Controller that turns one external simple dual-port RAM (1-cycle registered read, synchronous write, separate read/write ports) into a first-word-fall-through synchronous FIFO.
- Input and output sides use valid/ready handshakes.
- Sustains one push and one pop per cycle.
- Hides RAM read latency behind a 2-entry output buffer.
- Used between pixel-stream stages and the line/window buffers of the median pipeline.

Parameters:
DATA_WIDTH, 32, word width; must match the RAM data width.
ADDR_WIDTH, 14, RAM address width; RAM depth DEPTH = 2**ADDR_WIDTH.

Ports:
clk  input  1  clock; all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous clear of all contents.
s_valid  input  1  write-side data valid.
s_ready  output  1  write side can accept a word.
s_data  input  DATA_WIDTH  write-side data.
m_valid  output  1  head word valid.
m_ready  input  1  consumer takes head word.
m_data  output  DATA_WIDTH  head word.
count  output  ADDR_WIDTH+2  total words held (RAM + output buffer).
ram_w_ena  output  1  RAM write enable.
ram_w_addr  output  ADDR_WIDTH  RAM write address.
ram_w_data  output  DATA_WIDTH  RAM write data.
ram_r_ena  output  1  RAM read enable.
ram_r_addr  output  ADDR_WIDTH  RAM read address.
ram_r_data  input  DATA_WIDTH  RAM read data; valid the cycle after ram_r_ena.

Behaviour:
- State: wr_ptr, rd_ptr (ADDR_WIDTH, natural wrap DEPTH-1 -> 0), ram_cnt (0..DEPTH), rd_pending, 2-entry output buffer (head = m_data/m_valid, plus one skid entry).
- Reset (rst_n low, async): pointers, ram_cnt, count, rd_pending, buffer valids = 0. m_valid=0, m_data=0, s_ready=0, ram_w_ena=0, ram_r_ena=0, addresses=0.
- s_ready = rst_n deasserted && !flush && ram_cnt != DEPTH.
- Push when s_valid && s_ready:
  - Same cycle, combinationally: ram_w_ena=1, ram_w_addr=wr_ptr, ram_w_data=s_data.
  - wr_ptr increments.
- Pop when m_valid && m_ready: the head leaves and the skid entry, if valid, moves to head.
- Read issue in cycle t:
  - Condition: ram_cnt != 0 && (buf_occ + rd_pending - pop_t) < 2, where buf_occ = number of valid output-buffer entries.
  - ram_cnt counts only words written in earlier cycles, so a read never targets the address being written that cycle.
  - Action: ram_r_ena=1, ram_r_addr=rd_ptr, rd_ptr++, rd_pending set for t+1.
- Read return in cycle t+1: ram_r_data is written into the first free output-buffer slot after applying that cycle's pop. The issue condition guarantees a free slot exists.
- Ordering is strictly FIFO: RAM order, then skid entry, then head.
- ram_cnt next = ram_cnt + push - read_issue. count next = count + push - pop.
- Latency: push at t gives m_valid at t+2 when the FIFO was empty. No combinational path s_valid -> m_valid.
- Throughput: with m_ready held high and a steady input, one word per cycle in each direction after the fill latency.
- Capacity: DEPTH + 2 words. When full, s_ready=0 and s_valid is ignored. When empty, m_valid=0 and m_ready is ignored.
- Simultaneous push and pop while full: the pop frees a buffer slot, a read may issue, and the push is accepted only if ram_cnt != DEPTH at cycle start. No same-cycle fall-through.
- flush (synchronous, higher priority than push/pop/issue):
  - All state returns to reset values at the next edge.
  - Any in-flight read return is discarded.
  - During the flush cycle: ram_w_ena=0, ram_r_ena=0.
- Reset mid-operation: all contents lost and outputs return to reset values immediately. No RAM access until rst_n is released. First push accepted on the first edge after release.
- m_data holds its value while m_valid && !m_ready; it never changes under backpressure.

Decomposition:
- Shared package / header: DEPTH = 2**ADDR_WIDTH localparam, count-width constant, handshake fire macros or functions used across the median pipeline.
- One sub-module, fifo_out_buf: the 2-entry output buffer.
  - Inputs: load (ram_r_data, rd_pending), pop, flush.
  - Outputs: head valid/data, occupancy.
- sync_fifo_ctrl holds pointers, counters and read-issue logic.

Test Plan (ADDR_WIDTH=3, DEPTH=8, capacity 10):
1. Reset, then push 0x11 at t=0 with m_ready=0 -> ram_w_ena with addr 0 at t=0; ram_r_ena with addr 0 at t=1; m_valid=1, m_data=0x11 at t=2; count=1.
2. Push 0..11 with m_ready=0 -> 10 accepted; s_ready=0 after the 10th; count=10; then m_ready=1 -> m_data 0..9 in order on consecutive cycles; m_valid=0 after; count=0.
3. Continuous push/pop of 40 words with m_ready=1 -> rd/wr pointers wrap through 7->0 at least four times; output sequence equals input; one word per cycle in steady state.
4. Random m_ready (50%) and random s_valid over 1000 words -> scoreboard order match; m_data stable whenever m_valid && !m_ready; count never exceeds 10.
5. Fill with 6 words, assert flush for 1 cycle while a read is pending -> next cycle count=0, m_valid=0; the pending return is not delivered; next push 0xAB appears as m_data=0xAB two cycles later.
6. Drop rst_n asynchronously mid-burst (between clock edges) -> m_valid, s_ready, ram_w_ena, ram_r_ena go 0 immediately; after release, FIFO is empty and the first accepted word is the first output.
